// File: rtl/hilo_mult_unit.sv
// HI/LO execution unit: iterative shift-add multiplier with MUL/MADD/MSUB and moves to HI/LO.
// Optional early termination when the remaining multiplier bits are zero: MUL_EARLY_TERM_EN.
module hilo_mult_unit #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic        Flush,
    input  logic [4:0]  ALUControl,
    input  logic        Signed,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] ReadData,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int N  = 32 / BITS_PER_CYCLE;
    localparam int CW = 6;

    localparam logic [4:0] OP_MUL   = 5'b01001;
    localparam logic [4:0] OP_MOVTH = 5'b01010;
    localparam logic [4:0] OP_MOVTL = 5'b01011;
    localparam logic [4:0] OP_MFHI  = 5'b01100;
    localparam logic [4:0] OP_MADD  = 5'b01110;
    localparam logic [4:0] OP_MSUB  = 5'b01111;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC} state_t;

    state_t          r_state;
    logic [63:0]     r_mcand;
    logic [63:0]     r_pp;
    logic [31:0]     r_mplier;
    logic            r_sign;
    logic [4:0]      r_op;
    logic [CW-1:0]   r_cnt;
    logic            r_done;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;

    logic [31:0]     w_abs_a;
    logic [31:0]     w_abs_b;
    logic [63:0]     w_step;
    logic [31:0]     w_rest;
    logic            w_last;
    logic [63:0]     w_prod;
    logic [63:0]     w_hilo;
    logic [63:0]     w_acc;
    logic            w_is_mul;

    assign w_abs_a  = (Signed && A[31]) ? (~A + 32'd1) : A;
    assign w_abs_b  = (Signed && B[31]) ? (~B + 32'd1) : B;
    assign w_is_mul = (ALUControl == OP_MUL) || (ALUControl == OP_MADD)
                   || (ALUControl == OP_MSUB);

    // One iteration retires the low BITS_PER_CYCLE multiplier bits.
    always_comb begin
        w_step = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (r_mplier[j]) begin
                w_step = w_step + (r_mcand << j);
            end
        end
    end

    assign w_rest = r_mplier >> BITS_PER_CYCLE;

`ifdef MUL_EARLY_TERM_EN
    assign w_last = (r_cnt == CW'(N - 1)) || (w_rest == 32'd0);
`else
    assign w_last = (r_cnt == CW'(N - 1));
`endif

    assign w_prod = r_sign ? (~r_pp + 64'd1) : r_pp;
    assign w_hilo = {r_hi, r_lo};

    always_comb begin
        case (r_op)
            OP_MADD: w_acc = w_hilo + w_prod;
            OP_MSUB: w_acc = w_hilo - w_prod;
            default: w_acc = w_prod;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_pp     <= '0;
            r_mplier <= '0;
            r_sign   <= 1'b0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            if (Flush) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (Start) begin
                            if (ALUControl == OP_MOVTH) begin
                                r_hi <= A;
                            end else if (ALUControl == OP_MOVTL) begin
                                r_lo <= A;
                            end else if (w_is_mul) begin
                                r_mcand  <= {32'd0, w_abs_a};
                                r_mplier <= w_abs_b;
                                r_sign   <= Signed & (A[31] ^ B[31]);
                                r_op     <= ALUControl;
                                r_pp     <= '0;
                                r_cnt    <= '0;
                                r_state  <= S_MUL;
                            end
                        end
                    end
                    S_MUL: begin
                        r_pp     <= r_pp + w_step;
                        r_mcand  <= r_mcand << BITS_PER_CYCLE;
                        r_mplier <= w_rest;
                        r_cnt    <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= S_ACC;
                        end
                    end
                    S_ACC: begin
                        r_hi    <= w_acc[63:32];
                        r_lo    <= w_acc[31:0];
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign Busy     = (r_state != S_IDLE);
    assign Done     = r_done;
    assign HI       = r_hi;
    assign LO       = r_lo;
    assign ReadData = (ALUControl == OP_MFHI) ? r_hi : r_lo;

endmodule
